mod_sub_pipe: RTL and testbench

- Pipelined modular subtractor: computes c_o = (a_i - b_i) mod q_i.
- Inverse operation of the existing combinational modular adder. Feeds the lattice/NTT datapath in the pqvalue coprocessor, e.g. the butterfly difference leg.
- Operands may be partially reduced, in the range [0, 2q). The result is fully reduced, in the range [0, q).
- Two-stage registered pipeline with valid/ready handshake, one result per cycle, full backpressure.

---
 rtl/mod_sub_if.sv | 27 ++
 rtl/mod_sub_pipe.sv | 79 +++++++
 tb/tb_mod_sub_pipe.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/mod_sub_if.sv
// Operand/result handshake bundle for the pipelined modular subtractor.
// Signal names carry the subtractor's own direction suffixes so they read the same at the block and in the bench.
interface mod_sub_if #(
    parameter int QW = 23
);
    localparam int AW = QW + 1;

    logic          valid_i;
    logic          ready_o;
    logic [AW-1:0] a_i;
    logic [AW-1:0] b_i;
    logic [QW-1:0] q_i;
    logic          valid_o;
    logic          ready_i;
    logic [QW-1:0] c_o;
    logic          busy_o;

    modport master (
        output valid_i, a_i, b_i, q_i, ready_i,
        input  ready_o, valid_o, c_o, busy_o
    );

    modport slave (
        input  valid_i, a_i, b_i, q_i, ready_i,
        output ready_o, valid_o, c_o, busy_o
    );
endinterface

// File: rtl/mod_sub_pipe.sv
// Two-stage pipelined modular subtractor: c = (a - b) mod q.
// Operands a and b may be partially reduced ([0, 2q)); the result is fully reduced ([0, q)).
module mod_sub_pipe #(
    parameter int QW = 23,
    parameter int AW = QW + 1
) (
    input logic     clk_i,
    input logic     rst_ni,
    mod_sub_if.slave bus
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Inputs transfer on valid_i & ready_o; results transfer on valid_o & ready_i.
    // ready_o never depends on valid_i, and valid_o/c_o hold steady while stalled.

    logic          s1_valid;
    logic [QW-1:0] a_r;
    logic [QW-1:0] b_r;
    logic [QW-1:0] q_r;
    logic          out_valid;
    logic [QW-1:0] out_c;

    logic          adv1;
    logic          adv2;
    logic [QW-1:0] a_red;
    logic [QW-1:0] b_red;
    logic [AW-1:0] d;
    logic          borrow;
    logic [QW-1:0] d_plus_q;

    always_comb begin
        adv2 = ~out_valid | bus.ready_i;
        adv1 = ~s1_valid | adv2;
    end

    // Subtracting in QW bits gives the same low bits as the AW-bit subtraction.
    always_comb begin
        a_red = (bus.a_i >= {1'b0, bus.q_i}) ? (bus.a_i[QW-1:0] - bus.q_i) : bus.a_i[QW-1:0];
        b_red = (bus.b_i >= {1'b0, bus.q_i}) ? (bus.b_i[QW-1:0] - bus.q_i) : bus.b_i[QW-1:0];
    end

    always_comb begin
        d        = {1'b0, a_r} - {1'b0, b_r};
        borrow   = d[AW-1];
        d_plus_q = d[QW-1:0] + q_r;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            s1_valid <= 1'b0;
            a_r      <= '0;
            b_r      <= '0;
            q_r      <= '0;
        end else if (adv1) begin
            s1_valid <= bus.valid_i;
            a_r      <= a_red;
            b_r      <= b_red;
            q_r      <= bus.q_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            out_valid <= 1'b0;
            out_c     <= '0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_c <= borrow ? d_plus_q : d[QW-1:0];
            end
        end
    end

    always_comb begin
        bus.ready_o = adv1 & rst_ni;
        bus.valid_o = out_valid;
        bus.c_o     = out_c;
        bus.busy_o  = s1_valid | out_valid;
    end
endmodule

// File: tb/tb_mod_sub_pipe.sv
// Directed bench for mod_sub_pipe: reset, latency, wrap, partial reduction,
// streaming against a reference model, backpressure and mid-flight reset.
module tb_mod_sub_pipe;
    localparam int QW = 23;
    localparam int AW = QW + 1;
    localparam int Q  = 8380417;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [QW-1:0] exp_q[$];

    mod_sub_if #(.QW(QW)) bus ();

    mod_sub_pipe #(.QW(QW)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [QW-1:0] ref_sub(input longint a, input longint b);
        longint r;
        r = ((a % Q) - (b % Q) + Q) % Q;
        return r[QW-1:0];
    endfunction

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [AW-1:0] b);
        bus.valid_i = v;
        bus.a_i     = a;
        bus.b_i     = b;
    endtask

    // Accept one operand pair, confirm nothing at +1 edge and the result at +2 edges.
    task automatic single(input string tag, input logic [AW-1:0] a, input logic [AW-1:0] b,
                          input logic [QW-1:0] exp);
        drive(1'b1, a, b);
        check({tag, "_ready"}, 32'(bus.ready_o), 32'd1);
        step();
        drive(1'b0, '0, '0);
        check({tag, "_early"}, 32'(bus.valid_o), 32'd0);
        step();
        check({tag, "_valid"}, 32'(bus.valid_o), 32'd1);
        check({tag, "_c"}, 32'(bus.c_o), 32'(exp));
        step();
    endtask

    initial begin
        int rx;
        int first_cyc;
        int last_cyc;
        int cyc;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.ready_i = 1'b1;
        bus.q_i     = QW'(Q);
        drive(1'b0, '0, '0);

        step();
        step();
        check("rst_ready", 32'(bus.ready_o), 32'd0);
        check("rst_valid", 32'(bus.valid_o), 32'd0);
        check("rst_busy", 32'(bus.busy_o), 32'd0);
        check("rst_c", 32'(bus.c_o), 32'd0);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(bus.ready_o), 32'd1);
        step();

        single("basic", 24'd5, 24'd3, 23'd2);
        single("wrap1", 24'd3, 24'd5, 23'd8380415);
        single("wrap2", 24'd0, 24'd8380416, 23'd1);
        single("part1", 24'd8380418, 24'd1, 23'd0);
        single("part2", 24'd16760833, 24'd8380417, 23'd8380416);
        single("equal", 24'd12345, 24'd12345, 23'd0);

        // Streaming: 100 back-to-back pairs with ready_i held high.
        rx = 0;
        first_cyc = -1;
        last_cyc = -1;
        cyc = 0;
        for (int i = 0; i < 100; i++) begin
            ra = AW'($urandom_range(0, 2 * Q - 1));
            rb = AW'($urandom_range(0, 2 * Q - 1));
            drive(1'b1, ra, rb);
            check("stream_ready", 32'(bus.ready_o), 32'd1);
            exp_q.push_back(ref_sub(longint'(ra), longint'(rb)));
            step();
            cyc++;
            if (bus.valid_o) begin
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                rx++;
                check("stream_c", 32'(bus.c_o), 32'(exp_q.pop_front()));
            end
        end
        drive(1'b0, '0, '0);
        for (int k = 0; k < 10 && rx < 100; k++) begin
            step();
            cyc++;
            if (bus.valid_o) begin
                last_cyc = cyc;
                rx++;
                if (exp_q.size() > 0) check("stream_c", 32'(bus.c_o), 32'(exp_q.pop_front()));
            end
        end
        check("stream_count", 32'(rx), 32'd100);
        check("stream_consecutive", 32'(last_cyc - first_cyc), 32'd99);
        step();
        check("stream_idle", 32'(bus.busy_o), 32'd0);

        // Backpressure: two transfers fill both stages, third offer waits.
        bus.ready_i = 1'b0;
        drive(1'b1, 24'd9, 24'd4);
        check("bp_ready0", 32'(bus.ready_o), 32'd1);
        step();
        drive(1'b1, 24'd4, 24'd9);
        check("bp_ready1", 32'(bus.ready_o), 32'd1);
        step();
        drive(1'b1, 24'd7, 24'd7);
        check("bp_full", 32'(bus.ready_o), 32'd0);
        check("bp_valid", 32'(bus.valid_o), 32'd1);
        check("bp_c", 32'(bus.c_o), 32'd5);
        step();
        step();
        check("bp_hold_ready", 32'(bus.ready_o), 32'd0);
        check("bp_hold_c", 32'(bus.c_o), 32'd5);
        check("bp_hold_valid", 32'(bus.valid_o), 32'd1);
        bus.ready_i = 1'b1;
        #1;
        check("bp_resume_ready", 32'(bus.ready_o), 32'd1);
        step();
        drive(1'b0, '0, '0);
        check("bp_out2_valid", 32'(bus.valid_o), 32'd1);
        check("bp_out2_c", 32'(bus.c_o), 32'd8380412);
        step();
        check("bp_out3_valid", 32'(bus.valid_o), 32'd1);
        check("bp_out3_c", 32'(bus.c_o), 32'd0);
        step();
        check("bp_drained", 32'(bus.valid_o), 32'd0);
        check("bp_idle", 32'(bus.busy_o), 32'd0);

        // Reset with two entries in flight; an operand offered during reset is ignored.
        drive(1'b1, 24'd20, 24'd1);
        step();
        drive(1'b1, 24'd30, 24'd2);
        step();
        check("mid_busy", 32'(bus.busy_o), 32'd1);
        rst_n = 1'b0;
        drive(1'b1, 24'd50, 24'd1);
        step();
        check("mid_rst_valid", 32'(bus.valid_o), 32'd0);
        check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
        check("mid_rst_c", 32'(bus.c_o), 32'd0);
        check("mid_rst_ready", 32'(bus.ready_o), 32'd0);
        rst_n = 1'b1;
        drive(1'b0, '0, '0);
        step();
        check("no_stale1", 32'(bus.valid_o), 32'd0);
        step();
        check("no_stale2", 32'(bus.valid_o), 32'd0);
        single("after_rst", 24'd10, 24'd3, 23'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
